tiny_dnn_seq: RTL and testbench

//  Command sequencer driving one tiny_dnn_core MAC lane. Accepts load/compute commands over a valid/ready

---
 rtl/tiny_dnn_pkg.sv | 8 +
 rtl/tiny_dnn_seq.sv | 111 +++++++++++
 tb/tb_tiny_dnn_seq.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tiny_dnn_pkg.sv
// tiny_dnn_pkg: shared sizes, core pipeline depth and sequencer states for the tiny_dnn lane
package tiny_dnn_pkg;
    localparam int F_SIZE = 1024;
    localparam int ADDR_W = $clog2(F_SIZE);
    localparam logic [ADDR_W-1:0] BIAS_ADDR = ADDR_W'(F_SIZE - 1);
    localparam int CORE_LAT = 2;
    typedef enum logic [2:0] {IDLE, LOAD, INIT, RUN, BIAS, DRAIN, DONE} seq_state_t;
endpackage

// File: rtl/tiny_dnn_seq.sv
// tiny_dnn_seq: command sequencer feeding one tiny_dnn_core MAC lane and returning its dot product
// Define TINY_DNN_SEQ_BIAS_EN to load and apply the bias slot (entry F_SIZE-1) with every vector.
module tiny_dnn_seq #(
    parameter int F_SIZE = tiny_dnn_pkg::F_SIZE,
    parameter int ADDR_W = tiny_dnn_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_load,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              w_valid,
    output logic              w_ready,
    input  real               w_data,
    output logic [ADDR_W-1:0] f_addr,
    output logic              f_en,
    output logic              init,
    output logic              write,
    output logic              bwrite,
    output logic              exec,
    output logic              bias,
    output logic              update,
    output logic [ADDR_W-1:0] ra,
    output logic [ADDR_W-1:0] wa,
    output real               wd,
    input  real               sum,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_err,
    output real               res_data
);
    import tiny_dnn_pkg::*;
`ifdef TINY_DNN_SEQ_BIAS_EN
    localparam bit BIAS_EN = 1'b1;
`else
    localparam bit BIAS_EN = 1'b0;
`endif
    localparam logic [ADDR_W-1:0] SLOT = ADDR_W'(F_SIZE - 1);
    seq_state_t state, nxt;
    logic [ADDR_W-1:0] k, n;
    logic [CORE_LAT-1:0] sr;
    logic accept, bad, beat, bias_beat, last_beat, last_issue;
    assign res_valid = state == DONE;
    assign cmd_ready = state == IDLE && !res_valid;
    assign w_ready = state == LOAD;
    assign init = state == INIT;
    assign exec = state == RUN;
    assign bias = BIAS_EN && state == BIAS;
    assign f_en = exec;
    assign ra = exec ? k : '0;
    assign f_addr = ra;
    assign update = sr[CORE_LAT-1];
    assign res_data = sum;
    assign accept = cmd_valid && cmd_ready;
    assign bad = cmd_len == '0 || (BIAS_EN && cmd_len == SLOT);
    assign beat = w_valid && w_ready;
    assign bias_beat = BIAS_EN && k == n;
    assign last_beat = BIAS_EN ? k == n : k == n - ADDR_W'(1);
    // the bias cycle, when present, replaces the last exec as the final issue
    assign last_issue = (exec && !BIAS_EN && k == n - ADDR_W'(1)) || bias;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:  if (accept) nxt = bad ? DONE : cmd_load ? LOAD : INIT;
            LOAD:  if (beat && last_beat) nxt = IDLE;
            INIT:  nxt = RUN;
            RUN:   if (k == n - ADDR_W'(1)) nxt = BIAS_EN ? BIAS : DRAIN;
            BIAS:  nxt = DRAIN;
            DRAIN: if (sr[CORE_LAT-1]) nxt = DONE;
            DONE:  if (res_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // update fires CORE_LAT cycles after the last issue, when the core's final stage retires
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k <= '0;
            n <= '0;
            sr <= '0;
            res_err <= 1'b0;
            write <= 1'b0;
            bwrite <= 1'b0;
            wa <= '0;
            wd <= 0.0;
        end else begin
            sr <= {sr[CORE_LAT-2:0], last_issue};
            write <= beat;
            bwrite <= beat && bias_beat;
            if (beat) begin
                wa <= bias_beat ? SLOT : k;
                wd <= w_data;
            end
            if (accept) begin
                n <= cmd_len;
                k <= '0;
                res_err <= bad;
            end else if (beat || exec) begin
                k <= k + ADDR_W'(1);
            end
            if (res_valid && res_ready) res_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_tiny_dnn_seq.sv
// tb_tiny_dnn_seq: sequencer paired with a behavioural 2-stage MAC core and 1-cycle feature RAM;
// expected results go into a scoreboard queue that a monitor drains as results appear.
module tb_tiny_dnn_seq;
    localparam int AW = 10;
`ifdef TINY_DNN_SEQ_BIAS_EN
    localparam bit BE = 1'b1;
`else
    localparam bit BE = 1'b0;
`endif
    typedef struct {real data; bit err; int cyc;} exp_t;
    typedef struct {int wa; real wd; bit bw;} wr_t;

    logic clk = 1'b0, rst = 1'b0;
    logic cmd_valid = 1'b0, cmd_ready, cmd_load = 1'b0;
    logic [AW-1:0] cmd_len = '0;
    logic w_valid = 1'b0, w_ready;
    real w_data = 0.0;
    logic [AW-1:0] f_addr, ra, wa;
    logic f_en, init, write, bwrite, exec, bias, update;
    real wd, res_data;
    real sum = 0.0;
    logic res_valid, res_ready = 1'b1, res_err;

    real wmem [0:1023];
    real fmem [0:1023];
    real acc = 0.0, wr = 0.0, fq = 0.0;
    logic e1 = 1'b0, b1 = 1'b0;

    int cyc = 0, total = 0, bad = 0;
    int n_init = 0, n_exec = 0, n_bias = 0, n_bwr = 0, n_excl = 0;
    logic rv_q = 1'b0;
    exp_t exp_q[$];
    exp_t e_m;
    wr_t wlog[$];

    tiny_dnn_seq dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
        .cmd_len(cmd_len), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .f_addr(f_addr),
        .f_en(f_en), .init(init), .write(write), .bwrite(bwrite), .exec(exec), .bias(bias),
        .update(update), .ra(ra), .wa(wa), .wd(wd), .sum(sum), .res_valid(res_valid),
        .res_ready(res_ready), .res_err(res_err), .res_data(res_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // core: stage 1 reads weight and feature, stage 2 accumulates, update publishes the sum
    always @(posedge clk) begin
        if (write) wmem[bwrite ? 1023 : int'(wa)] <= wd;
        if (init) acc <= 0.0;
        else if (e1) acc <= acc + wr * fq;
        else if (b1) acc <= acc + wr;
        e1 <= exec;
        b1 <= bias;
        wr <= exec ? wmem[int'(ra)] : wmem[1023];
        if (f_en) fq <= fmem[int'(f_addr)];
        if (update) sum <= acc;
    end

    task automatic chk_i(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, want);
        end
    endtask

    task automatic chk_r(input string nm, input real got, input real want);
        total++;
        if (got > want + 1e-6 || got < want - 1e-6) begin
            bad++;
            $display("FAIL %s: got %f, expected %f", nm, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (write) wlog.push_back('{int'(wa), wd, bwrite});
        n_init += int'(init);
        n_exec += int'(exec);
        n_bias += int'(bias);
        n_bwr += int'(bwrite);
        if (int'(exec) + int'(bias) + int'(init) + int'(write) > 1) n_excl++;
        if (res_valid && !rv_q) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL res_unexpected: got result %f err=%0d, expected none", res_data, res_err);
            end else begin
                e_m = exp_q.pop_front();
                chk_i("res_err", int'(res_err), int'(e_m.err));
                if (!e_m.err) chk_r("res_data", res_data, e_m.data);
                chk_i("res_cycle", cyc, e_m.cyc);
            end
        end
        rv_q = res_valid;
    end

    function automatic int lat(input int n);
        return BE ? n + 5 : n + 4;
    endfunction

    task automatic send(input bit ld, input int len, output int waited, output int a);
        cmd_valid = 1'b1;
        cmd_load = ld;
        cmd_len = AW'(len);
        waited = 0;
        while (!cmd_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            total++;
            bad++;
            $display("FAIL cmd_timeout: cmd_ready 0 after %0d cycles, expected 1", waited);
        end
        @(posedge clk);
        #1;
        a = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic comp(input int n, input real want, input bit err);
        int w, a;
        send(1'b0, n, w, a);
        exp_q.push_back('{want, err, err ? a : a + lat(n) - 1});
    endtask

    task automatic drain(input int budget);
        int t = 0;
        while (exp_q.size() != 0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d results outstanding after %0d cycles, expected 0", exp_q.size(), t);
            exp_q.delete();
        end
    endtask

    task automatic beat(input real v, input bit gap);
        int t = 0;
        if (gap) begin
            w_valid = 1'b0;
            @(negedge clk);
        end
        w_valid = 1'b1;
        w_data = v;
        while (!w_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!w_ready) begin
            total++;
            bad++;
            $display("FAIL beat_timeout: w_ready 0 after %0d cycles, expected 1", t);
        end
        @(negedge clk);
        w_valid = 1'b0;
    endtask

    task automatic do_load(input real v[4], input int n, input real bv, input bit gap);
        int w, a;
        int nb = n + int'(BE);
        wlog.delete();
        send(1'b1, n, w, a);
        @(negedge clk);
        for (int i = 0; i < nb; i++) beat(i < n ? v[i] : bv, gap && (i % 2 == 1));
        repeat (2) @(negedge clk);
        chk_i("load_writes", wlog.size(), nb);
        for (int i = 0; i < wlog.size() && i < nb; i++) begin
            chk_i("load_wa", wlog[i].wa, i < n ? i : 1023);
            chk_r("load_wd", wlog[i].wd, i < n ? v[i] : bv);
            chk_i("load_bwrite", int'(wlog[i].bw), int'(i >= n));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        int w, a, ni, ne;
        for (int i = 0; i < 1024; i++) fmem[i] = i < 4 ? 1.0 : i < 8 ? 2.0 : 0.0;
        rst = 1'b1;
        #3;
        chk_i("rst_cmd_ready", int'(cmd_ready), 1);
        chk_i("rst_res_valid", int'(res_valid), 0);
        chk_i("rst_w_ready", int'(w_ready), 0);
        chk_i("rst_ctrl", int'({init, write, bwrite, exec, bias, update, f_en}), 0);
        chk_i("rst_addr", int'({wa, ra, f_addr}), 0);
        chk_r("rst_wd", wd, 0.0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        // weight beats offered while idle must be ignored
        w_valid = 1'b1;
        w_data = 9.0;
        repeat (3) @(negedge clk);
        chk_i("idle_w_ready", int'(w_ready), 0);
        chk_i("idle_writes", wlog.size(), 0);
        w_valid = 1'b0;
        do_load('{1.0, 2.0, 3.0, 4.0}, 4, 0.5, 1'b0);
        @(negedge clk);
        comp(4, BE ? 10.5 : 10.0, 1'b0);
        drain(40);
        @(negedge clk);
        ni = n_init;
        ne = n_exec;
        comp(0, 0.0, 1'b1);
        drain(10);
        repeat (3) @(negedge clk);
        chk_i("len0_init", n_init, ni);
        chk_i("len0_exec", n_exec, ne);
        chk_r("len0_sum", sum, BE ? 10.5 : 10.0);
        // second command waits until the stalled result is consumed
        res_ready = 1'b0;
        comp(4, BE ? 10.5 : 10.0, 1'b0);
        a = 0;
        while (!res_valid && a < 40) begin
            @(negedge clk);
            a++;
        end
        chk_i("b2b_first_valid", int'(res_valid), 1);
        fork
            begin
                repeat (5) @(negedge clk);
                res_ready = 1'b1;
            end
        join_none
        send(1'b0, 3, w, a);
        exp_q.push_back('{BE ? 6.5 : 6.0, 1'b0, a + lat(3) - 1});
        chk_i("b2b_wait", w, 6);
        drain(40);
        @(negedge clk);
        send(1'b0, 8, w, a);
        repeat (4) @(negedge clk);
        chk_i("run_before_rst", int'(exec), 1);
        #2 rst = 1'b1;
        #1;
        chk_i("arst_ctrl", int'({init, exec, bias, f_en, update, write}), 0);
        chk_i("arst_res_valid", int'(res_valid), 0);
        chk_i("arst_ra", int'(ra), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        comp(2, BE ? 3.5 : 3.0, 1'b0);
        drain(30);
        @(negedge clk);
        do_load('{5.0, 6.0, 7.0, 0.0}, 3, 0.25, 1'b1);
        @(negedge clk);
        comp(3, BE ? 18.25 : 18.0, 1'b0);
        drain(30);
        @(negedge clk);
        comp(1023, BE ? 0.0 : 22.0, BE);
        drain(1100);
        repeat (3) @(negedge clk);
        chk_i("exclusive_ctrl", n_excl, 0);
        chk_i("bias_pulses", n_bias, BE ? 5 : 0);
        chk_i("bwrite_pulses", n_bwr, BE ? 2 : 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
